mul_rr_arbiter: RTL

MUL_RR_ARBITER -- requirements
Module: mul_rr_arbiter

---
 rtl/mul_rr_arbiter_pkg.sv | 26 ++
 rtl/mul_rr_arbiter_wallace.sv | 28 ++
 rtl/mul_rr_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mul_rr_arbiter_pkg.sv
// Shared widths, operand/product types and the carry-save helper used by the
// multiplier tree.
package mul_arb_pkg;

    localparam int OPND_W = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 16;

    typedef logic [OPND_W-1:0] operand_t;
    typedef logic [PROD_W-1:0] product_t;

    typedef struct packed {
        product_t sum;
        product_t carry;
    } csa_t;

    // 3:2 compressor across a whole row; carries beyond PROD_W-1 cannot occur
    // for an 8x8 product, so dropping them is exact.
    function automatic csa_t csa(input product_t x, input product_t y, input product_t z);
        csa_t r;
        r.sum   = x ^ y ^ z;
        r.carry = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/mul_rr_arbiter_wallace.sv
// Unsigned 8x8 Wallace-tree multiplier: partial products reduced 8->6->4->3->2
// rows with carry-save adders, then one carry-propagate add.
module mul_rr_arbiter_wallace
    import mul_arb_pkg::*;
(
    input  operand_t i_a,
    input  operand_t i_b,
    output product_t o_prod
);

    product_t w_pp [OPND_W];
    csa_t     w_l1a, w_l1b, w_l2a, w_l2b, w_l3, w_l4;

    always_comb begin
        for (int i = 0; i < OPND_W; i++) begin
            w_pp[i] = PROD_W'(i_b[i] ? i_a : operand_t'(0)) << i;
        end
    end

    assign w_l1a  = csa(w_pp[0], w_pp[1], w_pp[2]);
    assign w_l1b  = csa(w_pp[3], w_pp[4], w_pp[5]);
    assign w_l2a  = csa(w_l1a.sum, w_l1a.carry, w_l1b.sum);
    assign w_l2b  = csa(w_l1b.carry, w_pp[6], w_pp[7]);
    assign w_l3   = csa(w_l2a.sum, w_l2a.carry, w_l2b.sum);
    assign w_l4   = csa(w_l3.sum, w_l3.carry, w_l2b.carry);
    assign o_prod = w_l4.sum + w_l4.carry;

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined 8x8 multiplier among NUM_REQ
// requesters: S1 holds granted operands, S2 holds the product and response.
module mul_rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OPND_W-1:0] req_a,
    input  logic [NUM_REQ*OPND_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PROD_W-1:0]         rsp_result,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count
);

    localparam logic [ID_W:0] NUM_REQ_X = (ID_W+1)'(NUM_REQ);

    logic [ID_W-1:0]  r_ptr;
    logic             r_s1_valid;
    operand_t         r_s1_a;
    operand_t         r_s1_b;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_s2_valid;
    product_t         r_prod;
    logic [ID_W-1:0]  r_s2_id;
    logic [CNT_W-1:0] r_op_count;

    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_req_hs;
    operand_t         w_sel_a;
    operand_t         w_sel_b;
    product_t         w_prod;

    // Scan offsets high-to-low so the nearest valid requester above ptr is the
    // one left standing.
    always_comb begin : arbitrate
        logic [ID_W:0] idx;
        idx     = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (idx >= NUM_REQ_X) begin
                idx = idx - NUM_REQ_X;
            end
            if (req_valid[idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_sel_a = req_a[i*OPND_W +: OPND_W];
                w_sel_b = req_b[i*OPND_W +: OPND_W];
            end
        end
    end

    assign w_s2_adv  = !r_s2_valid || rsp_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_req_hs  = w_found && w_s1_adv && !rst;
    assign req_ready = w_req_hs ? (NUM_REQ'(1) << w_win) : '0;

    mul_rr_arbiter_wallace u_mul (
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .o_prod (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_found;
            r_s1_a     <= w_sel_a;
            r_s1_b     <= w_sel_b;
            r_s1_id    <= w_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_prod     <= '0;
            r_s2_id    <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_prod     <= w_prod;
            r_s2_id    <= r_s1_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_op_count <= '0;
        end else begin
            if (w_req_hs) begin
                r_ptr <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            end
            if (r_s2_valid && rsp_ready) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign rsp_valid  = r_s2_valid;
    assign rsp_result = r_prod;
    assign rsp_id     = r_s2_id;
    assign busy       = r_s1_valid || r_s2_valid;
    assign op_count   = r_op_count;

endmodule
